mux_nch_rr_reg: RTL and testbench
=================================

Name: mux_nch_rr_reg

Overview:
- Parametrised, registered N:1 data multiplexer with a valid/ready handshake on every input and on the output.
- Two selection modes:
  - Direct: an external select picks the channel, as a classic mux.
  - Round-robin: the block scans for valid channels with fair rotation.
- Sits between multiple producer channels and a single consumer. Replaces fixed-width 4:1 select logic where backpressure and fairness are needed.

Parameters:
- N, 4, number of input channels; legal range is N >= 2.
- W, 8, data width per channel in bits.
- SW, $clog2(N), select/channel-index width; derived, not overridden.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- mode  in  1  0 = direct select via sel; 1 = round-robin
- sel  in  SW  channel index used in mode 0
- in_data  in  N*W  packed channel data; channel i occupies bits [i*W +: W]
- in_valid  in  N  per-channel valid
- in_ready  out  N  per-channel ready; combinational
- out_data  out  W  registered selected data
- out_ch  out  SW  index of the channel that supplied out_data
- out_valid  out  1  output holds a word
- out_ready  in  1  consumer accepts the word

Behaviour:
- Reset (rst_n low at a rising edge): out_valid=0, out_data=0, out_ch=0, rr_ptr=0. in_ready is 0 while rst_n is low.
- load_en = !out_valid || out_ready. The output register accepts a new word only when load_en is 1.
- Grant in mode 0:
  - grant = sel, valid only if sel < N and in_valid[sel]=1.
  - sel >= N (non-power-of-2 N) produces no grant.
- Grant in mode 1:
  - grant = first i with in_valid[i]=1, scanning rr_ptr, rr_ptr+1, ..., N-1, 0, ..., rr_ptr-1.
  - No grant if in_valid is all zeros.
- in_ready[i] = load_en && grant_found && (grant==i). At most one bit is set; the result is independent of in_valid[j] for j != grant.
- Transfer on channel i (in_valid[i] && in_ready[i] at the edge):
  - out_data <= in_data[i], out_ch <= i, out_valid <= 1.
  - rr_ptr <= (i==N-1) ? 0 : i+1, updated in both modes.
- load_en=1 with no grant: out_valid <= 0. out_data and out_ch hold their old values (don't-care).
- Backpressure: while out_valid=1 and out_ready=0, out_data, out_ch and out_valid are held stable, and all in_ready bits are 0.
- Latency: 1 cycle from input transfer to out_valid. Throughput is 1 word/cycle when out_ready stays high.
- Simultaneous pop and push: out_ready=1 with a grant in the same cycle replaces the word with no bubble.
- Mode or sel changes:
  - Sampled combinationally each cycle and affect only the next grant decision.
  - A word already held in the output register is not disturbed.
- rr_ptr wrap-around: rr_ptr advances N-1 -> 0.
- Reset mid-operation: a held word is discarded (out_valid=0) and rr_ptr returns to 0 on the reset edge.

Test Plan:
- Reset check (N=4, W=8): hold rst_n=0 for 2 cycles with all in_valid=1 -> out_valid=0, out_data=0x00, out_ch=0, in_ready=4'b0000.
- Mode 0 direct select: mode=0, sel=2, in_data={0x44,0x33,0x22,0x11}, in_valid=4'b1111, out_ready=1 -> in_ready=4'b0100; next cycle out_data=0x33, out_ch=2, out_valid=1. With in_valid[2]=0 -> no transfer and out_valid falls to 0.
- Round-robin fairness: mode=1, in_valid=4'b1111 held, out_ready=1 for 6 cycles -> out_ch sequence is 0,1,2,3,0,1 and out_valid stays 1 every cycle.
- Round-robin skip and wrap: mode=1, rr_ptr=3, in_valid=4'b0010 -> grant ch1 and rr_ptr becomes 2. Then in_valid=4'b1001 -> grant ch3, rr_ptr becomes 0, then ch0 is granted next.
- Backpressure: the output holds 0x22 from ch1 and out_ready=0 for 3 cycles while the inputs change -> out_data stays 0x22, out_ch stays 1, in_ready=0. On out_ready=1 the next granted word loads in the same cycle.
- Mid-operation reset with a mode switch: the output holds a word and rst_n=0 for 1 cycle -> out_valid=0, and the next round-robin grant starts from ch0. Switching mode 1->0 while the output is stalled leaves the held word unchanged.

Source files
------------

// File: rtl/mux_nch_rr_reg.sv
// Registered N:1 multiplexer with valid/ready handshakes on every input and on the output.
// The channel is chosen either by an external select (mode_i = 0) or by a fair round-robin
// scan that starts at the channel after the last one served (mode_i = 1).
//
// Ports:
//   clk_i        rising-edge clock
//   rst_ni       synchronous active-low reset
//   mode_i       0 = direct select via sel_i, 1 = round-robin
//   sel_i        channel index used in direct mode
//   in_data_i    packed channel data, channel i at [i*W +: W]
//   in_valid_i   per-channel valid
//   in_ready_o   per-channel ready (combinational, at most one bit set)
//   out_data_o   registered selected data
//   out_ch_o     index of the channel that supplied out_data_o
//   out_valid_o  output register holds a word
//   out_ready_i  consumer accepts the word
module mux_nch_rr_reg #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    mode_i,
  input  logic [$clog2(N)-1:0]    sel_i,
  input  logic [N*W-1:0]          in_data_i,
  input  logic [N-1:0]            in_valid_i,
  output logic [N-1:0]            in_ready_o,
  output logic [W-1:0]            out_data_o,
  output logic [$clog2(N)-1:0]    out_ch_o,
  output logic                    out_valid_o,
  input  logic                    out_ready_i
);

  localparam int unsigned SW = $clog2(N);

  logic [W-1:0]   out_data_q, out_data_d;
  logic [SW-1:0]  out_ch_q, out_ch_d;
  logic           out_valid_q, out_valid_d;
  logic [SW-1:0]  rr_ptr_q, rr_ptr_d;

  logic           load_en;
  logic           dir_found;
  logic           rr_found;
  logic [SW-1:0]  rr_idx;
  logic [2*N-1:0] valid_rot;
  int unsigned    rr_sum;
  logic           grant_found;
  logic [SW-1:0]  grant;
  logic [W-1:0]   grant_data;

  assign load_en = !out_valid_q || out_ready_i;

  // Out-of-range selects (non-power-of-2 N) never grant.
  assign dir_found = (32'(sel_i) < N) && in_valid_i[sel_i];

  // Rotate the valid vector so bit 0 is the channel at rr_ptr; the first set bit at offset j
  // maps back to channel (rr_ptr + j) mod N.
  always_comb begin
    rr_found  = 1'b0;
    rr_idx    = '0;
    rr_sum    = 0;
    valid_rot = {in_valid_i, in_valid_i} >> rr_ptr_q;
    for (int unsigned j = 0; j < N; j++) begin
      if (!rr_found && valid_rot[j]) begin
        rr_found = 1'b1;
        rr_sum   = 32'(rr_ptr_q) + j;
        if (rr_sum >= N) rr_sum = rr_sum - N;
        rr_idx   = SW'(rr_sum);
      end
    end
  end

  assign grant_found = mode_i ? rr_found : dir_found;
  assign grant       = mode_i ? rr_idx : sel_i;

  always_comb begin
    grant_data = '0;
    in_ready_o = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (grant == SW'(i)) begin
        grant_data    = in_data_i[i*W +: W];
        in_ready_o[i] = rst_ni && load_en && grant_found;
      end
    end
  end

  always_comb begin
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_valid_d = out_valid_q;
    rr_ptr_d    = rr_ptr_q;
    if (load_en) begin
      if (grant_found) begin
        out_data_d  = grant_data;
        out_ch_d    = grant;
        out_valid_d = 1'b1;
        rr_ptr_d    = (grant == SW'(N - 1)) ? '0 : grant + SW'(1);
      end else begin
        // Data and channel are left as-is; they are meaningless while out_valid is low.
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
      rr_ptr_q    <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign out_data_o  = out_data_q;
  assign out_ch_o    = out_ch_q;
  assign out_valid_o = out_valid_q;

endmodule

// File: tb/tb_mux_nch_rr_reg.sv
// Self-checking bench for mux_nch_rr_reg (N=4, W=8): directed scenarios followed by random
// traffic, all compared against a behavioural model of the multiplexer kept in this file.
module tb_mux_nch_rr_reg;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           mode;
  logic [1:0]     sel;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  logic [W-1:0]   out_data;
  logic [1:0]     out_ch;
  logic           out_valid;
  logic           out_ready;

  int checks = 0;
  int errors = 0;

  // Model state: held word, its channel, its valid flag, and the round-robin start channel.
  int m_v, m_d, m_c, m_ptr;

  always #5 clk = ~clk;

  mux_nch_rr_reg #(.N(N), .W(W)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .mode_i      (mode),
    .sel_i       (sel),
    .in_data_i   (in_data),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .out_data_o  (out_data),
    .out_ch_o    (out_ch),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  // Channel the model would grant this cycle, or -1 for none.
  function automatic int model_grant();
    if (!mode) return (int'(sel) < N && in_valid[sel]) ? int'(sel) : -1;
    for (int k = 0; k < N; k++) begin
      int idx = (m_ptr + k) % N;
      if (in_valid[idx]) return idx;
    end
    return -1;
  endfunction

  // One clock: check in_ready against the model, clock, advance the model, check the outputs.
  task automatic cycle();
    int g;
    logic [N-1:0] er;
    #1;
    g  = model_grant();
    er = '0;
    if (rst_n && (m_v == 0 || out_ready) && g >= 0) er[g] = 1'b1;
    chk("in_ready", in_ready, er);
    @(posedge clk);
    #1;
    if (!rst_n) begin
      m_v = 0; m_d = 0; m_c = 0; m_ptr = 0;
    end else if (m_v == 0 || out_ready) begin
      if (g >= 0) begin
        m_v   = 1;
        m_d   = int'(in_data[g*W +: W]);
        m_c   = g;
        m_ptr = (g + 1) % N;
      end else begin
        m_v = 0;
      end
    end
    chk("out_valid", out_valid, m_v);
    if (m_v != 0 || !rst_n) begin
      chk("out_data", out_data, m_d);
      chk("out_ch", out_ch, m_c);
    end
  endtask

  initial begin
    m_v = 0; m_d = 0; m_c = 0; m_ptr = 0;
    rst_n     = 1'b0;
    mode      = 1'b0;
    sel       = 2'd0;
    in_data   = {8'h44, 8'h33, 8'h22, 8'h11};
    in_valid  = 4'b1111;
    out_ready = 1'b1;

    // Reset held for two cycles with every channel valid.
    cycle();
    cycle();
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 8'h00);
    chk("rst_ch", out_ch, 0);
    chk("rst_ready", in_ready, 4'b0000);

    // Direct select of channel 2.
    rst_n = 1'b1;
    sel   = 2'd2;
    #1;
    chk("m0_ready", in_ready, 4'b0100);
    cycle();
    chk("m0_data", out_data, 8'h33);
    chk("m0_ch", out_ch, 2);
    chk("m0_valid", out_valid, 1);
    in_valid = 4'b1011;
    cycle();
    chk("m0_novalid", out_valid, 0);

    // Round-robin fairness from a fresh pointer.
    rst_n = 1'b0;
    cycle();
    rst_n    = 1'b1;
    mode     = 1'b1;
    in_valid = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      cycle();
      chk("rr_seq_ch", out_ch, i % N);
      chk("rr_seq_valid", out_valid, 1);
    end

    // Skip and wrap: move the pointer to 3 via a direct grant of channel 2.
    mode = 1'b0;
    sel  = 2'd2;
    cycle();
    mode     = 1'b1;
    in_valid = 4'b0010;
    cycle();
    chk("rr_skip_ch", out_ch, 1);
    in_valid = 4'b1001;
    cycle();
    chk("rr_wrap_ch3", out_ch, 3);
    cycle();
    chk("rr_wrap_ch0", out_ch, 0);

    // Backpressure: hold 0x22 from channel 1 while the inputs churn.
    mode     = 1'b0;
    sel      = 2'd1;
    in_valid = 4'b1111;
    in_data  = {8'h44, 8'h33, 8'h22, 8'h11};
    cycle();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_data  = $urandom;
      in_valid = 4'($urandom);
      mode     = 1'($urandom);
      sel      = 2'($urandom);
      cycle();
      chk("bp_data", out_data, 8'h22);
      chk("bp_ch", out_ch, 1);
      chk("bp_ready", in_ready, 4'b0000);
    end
    out_ready = 1'b1;
    mode      = 1'b1;
    in_valid  = 4'b1111;
    cycle();
    chk("bp_resume_ch", out_ch, 2);
    chk("bp_resume_valid", out_valid, 1);

    // Reset while a word is held, then a mode switch under stall.
    out_ready = 1'b0;
    rst_n     = 1'b0;
    cycle();
    chk("mid_rst_valid", out_valid, 0);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    in_data   = {8'hd4, 8'hc3, 8'hb2, 8'ha1};
    cycle();
    chk("mid_rst_ch0", out_ch, 0);
    chk("mid_rst_data", out_data, 8'ha1);
    out_ready = 1'b0;
    mode      = 1'b0;
    sel       = 2'd3;
    cycle();
    chk("mode_sw_data", out_data, 8'ha1);
    chk("mode_sw_ch", out_ch, 0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      rst_n     = ($urandom_range(39) != 0);
      mode      = 1'($urandom);
      sel       = 2'($urandom);
      in_data   = $urandom;
      in_valid  = 4'($urandom);
      out_ready = ($urandom_range(3) != 0);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
